// File: rtl/demux1_2_buf.sv
// Buffered 1-to-2 word demultiplexer: one valid/ready input stream is steered
// into one of two independent FIFOs, so a stalled consumer never blocks the other.

`ifndef WORDSIZE
`define WORDSIZE 8
`endif

module demux1_2_buf_fifo #(
    parameter int WIDTH = `WORDSIZE,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign w_pop   = o_valid & i_ready;

    // Storage is cleared on reset so data outputs read 0 until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= FULL_CNT);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_pop |-> (r_count != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        i_push |-> (!o_full || w_pop));
endmodule

module demux1_2_buf #(
    parameter int WIDTH = `WORDSIZE,
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [AW:0]      a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [AW:0]      b_count
);
    logic w_a_full;
    logic w_b_full;
    logic w_push;

    // Ready looks only at the selected FIFO's full flag, never at the consumers,
    // so a full FIFO refuses the push even when it is popping that same cycle.
    assign in_ready = in_sel ? !w_b_full : !w_a_full;
    assign w_push   = in_valid & in_ready;

    demux1_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push & ~in_sel),
        .i_wdata (in_data),
        .o_full  (w_a_full),
        .i_ready (a_ready),
        .o_valid (a_valid),
        .o_data  (a_data),
        .o_count (a_count)
    );

    demux1_2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push & in_sel),
        .i_wdata (in_data),
        .o_full  (w_b_full),
        .i_ready (b_ready),
        .o_valid (b_valid),
        .o_data  (b_data),
        .o_count (b_count)
    );
endmodule

// File: tb/tb_demux1_2_buf.sv
// Directed bench for demux1_2_buf: reset, routing, back-pressure, full-FIFO
// push refusal, wrapping stream with toggling ready, and reset mid-transfer.

module tb_demux1_2_buf;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic [AW:0]      a_count;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [AW:0]      b_count;

    int total = 0;
    int bad   = 0;

    demux1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int mcount;
        int sent;
        int recv;
        int cyc;
        bit push;
        bit pop;
        logic [WIDTH-1:0] q[$];

        // 1: reset with in_valid held high
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
        a_ready = 1'b0; b_ready = 1'b0;
        step();
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        chk("rst_hold_a_count", a_count, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();

        // 2: one word to each side, consumers ready
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        step();
        in_sel = 1'b1; in_data = 8'h22;
        chk("t2_a_valid", a_valid, 1);
        chk("t2_a_data", a_data, 8'h11);
        chk("t2_b_valid_early", b_valid, 0);
        step();
        in_valid = 1'b0;
        chk("t2_a_valid_once", a_valid, 0);
        chk("t2_b_valid", b_valid, 1);
        chk("t2_b_data", b_data, 8'h22);
        step();
        chk("t2_b_valid_once", b_valid, 0);

        // 3: fill A under back-pressure, B still accepts
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA0;
        step();
        in_data = 8'hA1;
        step();
        chk("t3_a_count", a_count, 2);
        in_data = 8'hA2;
        #1;
        chk("t3_ready_sel0", in_ready, 0);
        in_sel = 1'b1; in_data = 8'hB0;
        #1;
        chk("t3_ready_sel1", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t3_b_data", b_data, 8'hB0);
        chk("t3_a_count_hold", a_count, 2);
        chk("t3_a_data_stable", a_data, 8'hA0);

        // 4: A full with a_ready=1: pop only, then push+pop
        a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA2;
        #1;
        chk("t4_full_ready", in_ready, 0);
        step();
        chk("t4_c1_a_count", a_count, 1);
        chk("t4_c1_a_data", a_data, 8'hA1);
        chk("t4_b_drained", b_count, 0);
        #1;
        chk("t4_c2_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t4_c2_a_count", a_count, 1);
        chk("t4_c2_a_data", a_data, 8'hA2);
        step();
        chk("t4_a_empty", a_valid, 0);

        // 5: stream 0..7 into B with b_ready toggling
        mcount = 0; sent = 0; recv = 0; cyc = 0;
        in_sel = 1'b1; a_ready = 1'b0;
        while (recv < 8 && cyc < 60) begin
            b_ready  = (cyc % 2 == 0);
            in_valid = (sent < 8);
            in_data  = 8'(sent);
            #1;
            chk("t5_in_ready", in_ready, (mcount != DEPTH));
            push = in_valid && (mcount != DEPTH);
            pop  = (mcount != 0) && b_ready;
            if (pop) begin
                chk("t5_b_data", b_data, q.pop_front());
                recv++;
            end
            if (push) begin
                q.push_back(8'(sent));
                sent++;
            end
            step();
            mcount = mcount + int'(push) - int'(pop);
            chk("t5_b_count", b_count, mcount);
            cyc++;
        end
        in_valid = 1'b0;
        chk("t5_recv", recv, 8);
        chk("t5_b_valid_end", b_valid, 0);

        // 6: reset with a_count=2, b_count=1, then fresh pushes
        b_ready = 1'b0; a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h31;
        step();
        in_data = 8'h32;
        step();
        in_sel = 1'b1; in_data = 8'h41;
        step();
        in_valid = 1'b0;
        chk("t6_pre_a_count", a_count, 2);
        chk("t6_pre_b_count", b_count, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_a_count", a_count, 0);
        chk("t6_b_count", b_count, 0);
        chk("t6_a_valid", a_valid, 0);
        chk("t6_b_valid", b_valid, 0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h77;
        step();
        chk("t6_new_a_data", a_data, 8'h77);
        chk("t6_new_a_count", a_count, 1);
        in_sel = 1'b1; in_data = 8'h88;
        step();
        in_valid = 1'b0;
        chk("t6_new_b_data", b_data, 8'h88);
        chk("t6_new_b_count", b_count, 1);
        chk("t6_a_still", a_data, 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
